// File: rtl/da_bitslice_feeder.sv
// -----------------------------------------------------------------------------
// da_bitslice_feeder
//   Upstream feeder for a 64-tap distributed-arithmetic FIR core. It keeps a
//   64-sample delay line, organised as 8 groups of 8 taps. Each accepted sample
//   is shifted in, and then the whole line is presented one bit-plane at a time,
//   MSB first, on eight 8-bit ROM address buses.
//
// Ports
//   clk, resetn    clock; synchronous active-low reset
//   sample_in      new sample x[n] (DATA_W bits, two's complement)
//   sample_valid   sample_in is valid
//   sample_ready   sample can be accepted (IDLE, cload low, resetn high)
//   cload          coefficient ROM load in progress; blocks sample acceptance
//   A7..A0         plane address; Ak[j] = bit b of tap x[8k+j]
//   plane_valid    A7..A0 carry a valid plane
//   plane_ready    consumer has taken the current plane
//   sign_plane     current plane is the sign plane (b == DATA_W-1)
//   plane_idx      current bit index b
//   start_out      one-cycle pulse when a new sample begins
//   frame_done     one-cycle pulse after the last plane (b = 0) is taken
//   fsm_state      current FSM state (debug visibility)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A valid source holds its payload stable until that edge;
// ready may change freely and is ignored while valid is low.
// -----------------------------------------------------------------------------
module da_bitslice_feeder #(
   parameter int DATA_W = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [DATA_W-1:0]         sample_in,
   input  logic                      sample_valid,
   output logic                      sample_ready,
   input  logic                      cload,
   output logic [7:0]                A7,
   output logic [7:0]                A6,
   output logic [7:0]                A5,
   output logic [7:0]                A4,
   output logic [7:0]                A3,
   output logic [7:0]                A2,
   output logic [7:0]                A1,
   output logic [7:0]                A0,
   output logic                      plane_valid,
   input  logic                      plane_ready,
   output logic                      sign_plane,
   output logic [$clog2(DATA_W)-1:0] plane_idx,
   output logic                      start_out,
   output logic                      frame_done,
   output logic [1:0]                fsm_state
);

   localparam int IDX_W = $clog2(DATA_W);
   localparam int TAPS  = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      PLANE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] line [TAPS];
   logic [TAPS-1:0]   plane_bits;
   logic              accept;

   assign accept = sample_valid & sample_ready;

   // State, bit index and delay line. The line only moves on an accepted
   // sample, so the plane addresses stay stable while a plane is stalled.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         bit_idx <= '0;
         for (int i = 0; i < TAPS; i++) begin
            line[i] <= '0;
         end
      end else begin
         state <= state_next;
         if (accept) begin
            line[0] <= sample_in;
            for (int i = 1; i < TAPS; i++) begin
               line[i] <= line[i-1];
            end
         end
         if (state == START) begin
            bit_idx <= IDX_W'(DATA_W - 1);
         end else if (state == PLANE && plane_ready && bit_idx != '0) begin
            bit_idx <= bit_idx - 1'b1;
         end
      end
   end

   always_comb begin
      state_next   = state;
      sample_ready = 1'b0;
      start_out    = 1'b0;
      plane_valid  = 1'b0;
      frame_done   = 1'b0;
      case (state)
         IDLE: begin
            // resetn is folded in so ready is never advertised during reset.
            sample_ready = ~cload & resetn;
            if (sample_valid & ~cload & resetn) begin
               state_next = START;
            end
         end
         START: begin
            start_out  = 1'b1;
            state_next = PLANE;
         end
         PLANE: begin
            plane_valid = 1'b1;
            if (plane_ready && bit_idx == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bit-select only: no sign extension; the consumer negates the sign plane.
   // Addresses are forced to zero outside PLANE so idle buses are quiet.
   always_comb begin
      plane_bits = '0;
      if (state == PLANE) begin
         for (int i = 0; i < TAPS; i++) begin
            plane_bits[i] = line[i][bit_idx];
         end
      end
   end

   assign A0 = plane_bits[7:0];
   assign A1 = plane_bits[15:8];
   assign A2 = plane_bits[23:16];
   assign A3 = plane_bits[31:24];
   assign A4 = plane_bits[39:32];
   assign A5 = plane_bits[47:40];
   assign A6 = plane_bits[55:48];
   assign A7 = plane_bits[63:56];

   assign plane_idx  = bit_idx;
   assign sign_plane = (state == PLANE) && (bit_idx == IDX_W'(DATA_W - 1));
   assign fsm_state  = state;

endmodule

// File: tb/tb_da_bitslice_feeder.sv
// -----------------------------------------------------------------------------
// tb_da_bitslice_feeder
//   Directed bench for da_bitslice_feeder. Stimulus pushes the expected plane
//   sequence for each accepted sample into exp_q; an independent monitor pops
//   and compares on every plane handshake.
// -----------------------------------------------------------------------------
module tb_da_bitslice_feeder;

   localparam int DATA_W = 16;

   logic              clk;
   logic              resetn;
   logic [DATA_W-1:0] sample_in;
   logic              sample_valid;
   logic              sample_ready;
   logic              cload;
   logic [7:0]        A7, A6, A5, A4, A3, A2, A1, A0;
   logic              plane_valid;
   logic              plane_ready;
   logic              sign_plane;
   logic [3:0]        plane_idx;
   logic              start_out;
   logic              frame_done;
   logic [1:0]        fsm_state;

   da_bitslice_feeder #(.DATA_W(DATA_W)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .cload        (cload),
      .A7           (A7),
      .A6           (A6),
      .A5           (A5),
      .A4           (A4),
      .A3           (A3),
      .A2           (A2),
      .A1           (A1),
      .A0           (A0),
      .plane_valid  (plane_valid),
      .plane_ready  (plane_ready),
      .sign_plane   (sign_plane),
      .plane_idx    (plane_idx),
      .start_out    (start_out),
      .frame_done   (frame_done),
      .fsm_state    (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [68:0]       exp_q[$];      // {A7..A0, sign_plane, plane_idx}
   logic [DATA_W-1:0] m_line [64];
   int total = 0;
   int bad = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   int hs_cnt = 0;
   int sign_cnt = 0;
   int exp_starts = 0;
   int exp_dones = 0;
   logic [63:0] last_p0 = '0;

   function automatic logic [63:0] addr_bus();
      return {A7, A6, A5, A4, A3, A2, A1, A0};
   endfunction

   function automatic logic [68:0] exp_plane(input int b);
      logic [63:0] v;
      for (int i = 0; i < 64; i++) v[i] = m_line[i][b];
      return {v, (b == DATA_W - 1), 4'(b)};
   endfunction

   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: timeout", name);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (start_out === 1'b1) start_cnt++;
         if (frame_done === 1'b1) done_cnt++;
         if (plane_valid === 1'b1 && plane_ready === 1'b1) begin
            hs_cnt++;
            if (sign_plane === 1'b1) sign_cnt++;
            if (plane_idx == 4'd0) last_p0 = addr_bus();
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL plane_extra: got %h want none", {addr_bus(), sign_plane, plane_idx});
            end else begin
               check("plane", {addr_bus(), sign_plane, plane_idx}, exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_model();
      for (int i = 0; i < 64; i++) m_line[i] = '0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("ready_in_reset", sample_ready, 1'b0);
      resetn = 1'b1;
      clear_model();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input logic [DATA_W-1:0] v);
      int n;
      n = 0;
      sample_in = v;
      sample_valid = 1'b1;
      while (sample_ready !== 1'b1) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 200) begin
            fail_now("accept");
            sample_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      exp_starts++;
      for (int i = 63; i > 0; i--) m_line[i] = m_line[i-1];
      m_line[0] = v;
      for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(exp_plane(b));
   endtask

   // Sends one sample and follows its frame to completion. With lat_check set,
   // plane_ready must be held high, and frame_done is required 17 cycles after
   // the start pulse (16 planes back to back, then DONE).
   task automatic run_frame(input logic [DATA_W-1:0] v, input bit lat_check);
      int n;
      int h0;
      int s0;
      h0 = hs_cnt;
      s0 = sign_cnt;
      send_sample(v);
      check("start_pulse", start_out, 1'b1);
      n = 0;
      while (frame_done !== 1'b1) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 400) begin
            fail_now("frame_done");
            return;
         end
      end
      if (lat_check) check_int("frame_len", n, 17);
      exp_dones++;
      @(posedge clk);
      #1;
      check("ready_after_done", sample_ready, 1'b1);
      check_int("queue_drained", exp_q.size(), 0);
      check_int("planes_per_frame", hs_cnt - h0, DATA_W);
      check_int("sign_planes", sign_cnt - s0, 1);
      check_int("start_count", start_cnt, exp_starts);
      check_int("done_count", done_cnt, exp_dones);
   endtask

   task automatic stall_at_9();
      logic [67:0] snap;
      int n;
      n = 0;
      while (!(plane_valid === 1'b1 && plane_idx == 4'd9)) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 200) begin
            fail_now("reach_b9");
            return;
         end
      end
      plane_ready = 1'b0;
      snap = {addr_bus(), plane_idx};
      repeat (5) begin
         @(posedge clk);
         #1;
         check("stall_hold", {plane_valid, addr_bus(), plane_idx}, {1'b1, snap});
      end
      plane_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall_advance", plane_idx, 4'd8);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      resetn = 1'b0;
      sample_in = '0;
      sample_valid = 1'b0;
      cload = 1'b0;
      plane_ready = 1'b1;
      clear_model();
      do_reset();

      // reset values
      check("rst_plane_valid", plane_valid, 1'b0);
      check("rst_start", start_out, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_sign", sign_plane, 1'b0);
      check("rst_idx", plane_idx, 4'd0);
      check("rst_addr", addr_bus(), 64'h0);
      check("rst_state", fsm_state, 2'd0);
      check("rst_ready", sample_ready, 1'b1);

      // single LSB sample: only A0[0] at plane 0
      run_frame(16'h0001, 1'b1);
      check("p0_after_0001", last_p0, 64'h0000_0000_0000_0001);

      // second sample: plane 0 sees both taps
      run_frame(16'h0003, 1'b1);
      check("p0_after_0003", last_p0, 64'h0000_0000_0000_0003);

      // all-ones into a cleared line
      do_reset();
      run_frame(16'hFFFF, 1'b1);
      check("p0_after_ffff", last_p0, 64'h0000_0000_0000_0001);

      // fill the line with ones, then push a zero
      for (int i = 0; i < 64; i++) run_frame(16'h0001, 1'b1);
      run_frame(16'h0000, 1'b1);
      check("p0_full_line", last_p0, 64'hFFFF_FFFF_FFFF_FFFE);

      // back-pressure on plane b = 9
      fork
         run_frame(16'h1234, 1'b0);
         stall_at_9();
      join

      // cload blocks acceptance
      cload = 1'b1;
      sample_in = 16'h00A5;
      sample_valid = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         check("cload_ready", sample_ready, 1'b0);
      end
      check_int("cload_no_start", start_cnt, exp_starts);
      sample_valid = 1'b0;
      cload = 1'b0;
      @(posedge clk);
      #1;

      // reset in the middle of a frame
      send_sample(16'h0101);
      n = 0;
      while (!(plane_valid === 1'b1 && plane_idx == 4'd7)) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 200) begin
            fail_now("reach_b7");
            break;
         end
      end
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_valid", plane_valid, 1'b0);
      check("midrst_ready", sample_ready, 1'b0);
      clear_model();
      resetn = 1'b1;
      @(posedge clk);
      #1;
      check_int("midrst_no_done", done_cnt, exp_dones);
      check("midrst_state", fsm_state, 2'd0);
      run_frame(16'h0002, 1'b1);
      check("p0_after_clear", last_p0, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
